// File: rtl/or1200_vlx_pkg.sv
// or1200_vlx_pkg: shared state encoding, SPR indices and JPEG byte constants for the VLX path
package or1200_vlx_pkg;
  typedef enum logic [1:0] {IDLE, EMIT, STUFF} vlx_state_t;
  localparam logic [1:0] VLX_SPR_CNT = 2'b00;
  localparam logic [1:0] VLX_SPR_FLUSH = 2'b01;
  localparam logic [1:0] VLX_SPR_ADDR = 2'b10;
  localparam logic [7:0] JPEG_MARKER = 8'hFF;
  localparam logic [7:0] JPEG_STUFF = 8'h00;
endpackage

// File: rtl/or1200_vlx_ctrl_if.sv
// or1200_vlx_ctrl_if: byte-store req/ack bus; master = VLX sequencer, slave = data store
interface or1200_vlx_ctrl_if #(parameter int ADDR_W = 32);
  logic st_req_o;
  logic [ADDR_W-1:0] st_addr_o;
  logic [7:0] st_byte_o;
  logic st_ack_i;
  modport master(output st_req_o, st_addr_o, st_byte_o, input st_ack_i);
  modport slave(input st_req_o, st_addr_o, st_byte_o, output st_ack_i);
endinterface

// File: rtl/or1200_vlx_bitbuf.sv
// or1200_vlx_bitbuf: MSB-first bit accumulator; merge_i appends bits, pad_i fills to a byte with 1s, shift_i drops the top byte
module or1200_vlx_bitbuf #(parameter int ACC_W = 32) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             merge_i,
  input  logic             pad_i,
  input  logic             shift_i,
  input  logic [15:0]      val_i,
  input  logic [4:0]       len_i,
  output logic [ACC_W-1:0] acc_o,
  output logic [5:0]       cnt_o
);
  logic [15:0] vl;
  logic [ACC_W-1:0] ins, pad_bits;
  // left-justify the masked value within 16 bits, then slide it below the bits already held
  always_comb begin
    vl = (val_i & 16'((17'd1 << len_i) - 17'd1)) << (5'd16 - len_i);
    ins = {vl, {(ACC_W-16){1'b0}}} >> cnt_o;
    pad_bits = {8'hFF >> cnt_o[2:0], {(ACC_W-8){1'b0}}};
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      acc_o <= '0;
      cnt_o <= '0;
    end else if (merge_i) begin
      acc_o <= acc_o | ins;
      cnt_o <= cnt_o + 6'(len_i);
    end else if (pad_i) begin
      acc_o <= acc_o | pad_bits;
      cnt_o <= 6'd8;
    end else if (shift_i) begin
      acc_o <= acc_o << 8;
      cnt_o <= cnt_o - 6'd8;
    end
endmodule

// File: rtl/or1200_vlx_ctrl.sv
// or1200_vlx_ctrl: VLX sequencer; packs CPU bit writes, drains bytes with 0xFF stuffing over st, stalls CPU while draining
module or1200_vlx_ctrl import or1200_vlx_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int ACC_W = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        bit_op_i,
  input  logic [15:0] bit_val_i,
  input  logic [4:0]  bit_len_i,
  input  logic        spr_cs_i,
  input  logic        spr_write_i,
  input  logic [1:0]  spr_addr_i,
  input  logic [31:0] spr_dat_i,
  output logic [31:0] spr_dat_o,
  output logic        stall_cpu_o,
  or1200_vlx_ctrl_if.master st
);
  vlx_state_t state, state_n;
  logic [ACC_W-1:0] acc;
  logic [5:0] cnt;
  logic [ADDR_W-1:0] addr;
  logic [7:0] top;
  logic gap, idle, req, ack, full, merge, flush_wr, pad, addr_wr;
  or1200_vlx_bitbuf #(.ACC_W(ACC_W)) u_bitbuf (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .merge_i(merge),
    .pad_i(pad),
    .shift_i(ack & state == EMIT),
    .val_i(bit_val_i),
    .len_i(bit_len_i),
    .acc_o(acc),
    .cnt_o(cnt)
  );
  // gap forces st_req_o low for the cycle after every ack, even when another byte is pending
  always_comb begin
    idle = state == IDLE;
    top = acc[ACC_W-1 -: 8];
    req = ~idle & ~gap;
    ack = st.st_ack_i & req;
    full = cnt + 6'(bit_len_i) >= 6'd8;
    flush_wr = spr_cs_i & spr_write_i & spr_addr_i == VLX_SPR_FLUSH;
    merge = idle & bit_op_i;
    pad = idle & ~bit_op_i & flush_wr & |cnt;
    addr_wr = idle & spr_cs_i & spr_write_i & spr_addr_i == VLX_SPR_ADDR;
    state_n = idle ? ((merge & full) | pad ? EMIT : IDLE) :
              ~ack ? state :
              state == EMIT ? (top == JPEG_MARKER ? STUFF : cnt >= 6'd16 ? EMIT : IDLE) :
              cnt >= 6'd8 ? EMIT : IDLE;
    st.st_req_o = req;
    st.st_byte_o = state == EMIT ? top : JPEG_STUFF;
    st.st_addr_o = addr;
    stall_cpu_o = ~idle | (bit_op_i & full) | (flush_wr & |cnt);
    spr_dat_o = ~spr_cs_i ? 32'd0 :
                spr_addr_i == VLX_SPR_CNT ? {26'd0, cnt} :
                spr_addr_i == VLX_SPR_ADDR ? 32'(addr) : 32'd0;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      addr <= '0;
      gap <= 1'b0;
    end else begin
      state <= state_n;
      gap <= ack;
      if (addr_wr) addr <= spr_dat_i[ADDR_W-1:0];
      else if (ack) addr <= addr + 1'b1;
    end
endmodule

// File: tb/tb_or1200_vlx_ctrl.sv
// tb_or1200_vlx_ctrl: directed self-checking bench for the VLX sequencer
module tb_or1200_vlx_ctrl;
  logic clk_i = 0, rst_ni = 0, bit_op_i = 0, spr_cs_i = 0, spr_write_i = 0;
  logic [15:0] bit_val_i = 0;
  logic [4:0] bit_len_i = 0;
  logic [1:0] spr_addr_i = 0;
  logic [31:0] spr_dat_i = 0, spr_dat_o, rd;
  logic stall_cpu_o;
  int checks = 0, failures = 0;
  logic [7:0] q_b[$];
  logic [31:0] q_a[$];
  int q_w[$];
  bit q_s[$];
  or1200_vlx_ctrl_if #(.ADDR_W(32)) st();
  or1200_vlx_ctrl #(.ADDR_W(32), .ACC_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bit_op_i(bit_op_i), .bit_val_i(bit_val_i),
    .bit_len_i(bit_len_i), .spr_cs_i(spr_cs_i), .spr_write_i(spr_write_i),
    .spr_addr_i(spr_addr_i), .spr_dat_i(spr_dat_i), .spr_dat_o(spr_dat_o),
    .stall_cpu_o(stall_cpu_o), .st(st.master)
  );
  always #5 clk_i = ~clk_i;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic spr_wr(input logic [1:0] a, input logic [31:0] d);
    spr_cs_i = 1; spr_write_i = 1; spr_addr_i = a; spr_dat_i = d;
    tick;
    spr_cs_i = 0; spr_write_i = 0;
  endtask
  task automatic spr_rd(input logic [1:0] a, output logic [31:0] d);
    spr_cs_i = 1; spr_write_i = 0; spr_addr_i = a;
    #1 d = spr_dat_o;
    spr_cs_i = 0;
  endtask
  task automatic op(input logic [15:0] v, input logic [4:0] l);
    bit_op_i = 1; bit_val_i = v; bit_len_i = l;
  endtask
  // acts as the data store: logs each accepted byte, its address, cycles req was low beforehand, and hold stability
  task automatic serve(input int n, input int dly);
    q_b.delete(); q_a.delete(); q_w.delete(); q_s.delete();
    for (int i = 0; i < n; i++) begin
      int t = 0;
      bit s = 1;
      logic [7:0] b;
      logic [31:0] a;
      while (!st.st_req_o && t < 50) begin tick; t++; end
      if (t == 50) break;
      b = st.st_byte_o; a = st.st_addr_o;
      repeat (dly) begin
        tick;
        if (st.st_byte_o !== b || st.st_addr_o !== a || st.st_req_o !== 1'b1) s = 0;
      end
      st.st_ack_i = 1;
      tick;
      st.st_ack_i = 0;
      q_b.push_back(b); q_a.push_back(a); q_w.push_back(t); q_s.push_back(s);
    end
  endtask
  task automatic test_reset;
    #2;
    checks++; if (st.st_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", st.st_req_o); end
    checks++; if (stall_cpu_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_cpu_o); end
    checks++; if (st.st_byte_o !== 8'h00 || st.st_addr_o !== 32'h0) begin failures++; $display("FAIL reset_bus got=%h@%h exp=00@0", st.st_byte_o, st.st_addr_o); end
    tick; tick;
    rst_ni = 1;
    tick;
    spr_rd(2'b00, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", rd); end
  endtask
  task automatic test_merge_small;
    spr_wr(2'b10, 32'h1000);
    op(16'h0005, 5'd3);
    #1;
    checks++; if (stall_cpu_o !== 1'b0) begin failures++; $display("FAIL small_stall got=%b exp=0", stall_cpu_o); end
    tick;
    bit_op_i = 0;
    checks++; if (st.st_req_o !== 1'b0) begin failures++; $display("FAIL small_req got=%b exp=0", st.st_req_o); end
    spr_rd(2'b00, rd);
    checks++; if (rd !== 32'd3) begin failures++; $display("FAIL small_cnt got=%0d exp=3", rd); end
  endtask
  task automatic test_emit;
    op(16'h001F, 5'd5);
    #1;
    checks++; if (stall_cpu_o !== 1'b1) begin failures++; $display("FAIL emit_stall got=%b exp=1", stall_cpu_o); end
    tick;
    bit_op_i = 0;
    checks++; if (st.st_req_o !== 1'b1) begin failures++; $display("FAIL emit_latency got=%b exp=1", st.st_req_o); end
    serve(1, 3);
    checks++; if (q_b.size() !== 1 || q_b[0] !== 8'hBF || q_a[0] !== 32'h1000) begin failures++; $display("FAIL emit_byte got=%h@%h exp=bf@1000", q_b[0], q_a[0]); end
    checks++; if (q_s[0] !== 1'b1) begin failures++; $display("FAIL emit_hold got=%b exp=1", q_s[0]); end
    checks++; if (st.st_req_o !== 1'b0 || stall_cpu_o !== 1'b0) begin failures++; $display("FAIL emit_idle got=%b%b exp=00", st.st_req_o, stall_cpu_o); end
    spr_rd(2'b10, rd);
    checks++; if (rd !== 32'h1001) begin failures++; $display("FAIL emit_addr got=%h exp=1001", rd); end
    spr_rd(2'b00, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL emit_cnt got=%0d exp=0", rd); end
  endtask
  task automatic test_stuff;
    spr_wr(2'b10, 32'h2000);
    op(16'h00FF, 5'd8);
    tick;
    bit_op_i = 0;
    serve(2, 0);
    checks++; if (q_b.size() !== 2 || q_b[0] !== 8'hFF || q_a[0] !== 32'h2000) begin failures++; $display("FAIL stuff_marker got=%h@%h exp=ff@2000", q_b[0], q_a[0]); end
    checks++; if (q_b[1] !== 8'h00 || q_a[1] !== 32'h2001) begin failures++; $display("FAIL stuff_zero got=%h@%h exp=00@2001", q_b[1], q_a[1]); end
    checks++; if (q_w[1] !== 1) begin failures++; $display("FAIL stuff_gap got=%0d exp=1", q_w[1]); end
    spr_rd(2'b10, rd);
    checks++; if (rd !== 32'h2002) begin failures++; $display("FAIL stuff_addr got=%h exp=2002", rd); end
  endtask
  task automatic test_long;
    logic [7:0] eb[4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    spr_wr(2'b10, 32'h3000);
    op(16'h007F, 5'd7);
    tick;
    op(16'hFFFF, 5'd16);
    #1;
    checks++; if (stall_cpu_o !== 1'b1) begin failures++; $display("FAIL long_stall got=%b exp=1", stall_cpu_o); end
    tick;
    bit_op_i = 0;
    serve(4, 1);
    checks++; if (q_b.size() !== 4) begin failures++; $display("FAIL long_count got=%0d exp=4", q_b.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (q_b[i] !== eb[i] || q_a[i] !== 32'h3000 + 32'(i) || q_s[i] !== 1'b1) begin failures++; $display("FAIL long_byte%0d got=%h@%h hold=%b exp=%h@%h hold=1", i, q_b[i], q_a[i], q_s[i], eb[i], 32'h3000 + 32'(i)); end
      if (i > 0) begin checks++; if (q_w[i] < 1) begin failures++; $display("FAIL long_gap%0d got=%0d exp>=1", i, q_w[i]); end end
    end
    spr_rd(2'b00, rd);
    checks++; if (rd !== 32'd7) begin failures++; $display("FAIL long_cnt got=%0d exp=7", rd); end
    spr_wr(2'b01, 32'h0);
    serve(2, 0);
    checks++; if (q_b.size() !== 2 || q_b[0] !== 8'hFF || q_a[0] !== 32'h3004 || q_b[1] !== 8'h00) begin failures++; $display("FAIL long_residue got=%h@%h,%h exp=ff@3004,00", q_b[0], q_a[0], q_b[1]); end
  endtask
  task automatic test_flush;
    spr_wr(2'b10, 32'h4000);
    op(16'h0005, 5'd3);
    tick;
    bit_op_i = 0;
    spr_cs_i = 1; spr_write_i = 1; spr_addr_i = 2'b01;
    #1;
    checks++; if (stall_cpu_o !== 1'b1) begin failures++; $display("FAIL flush_stall got=%b exp=1", stall_cpu_o); end
    tick;
    spr_cs_i = 0; spr_write_i = 0;
    serve(1, 0);
    checks++; if (q_b.size() !== 1 || q_b[0] !== 8'hBF || q_a[0] !== 32'h4000) begin failures++; $display("FAIL flush_byte got=%h@%h exp=bf@4000", q_b[0], q_a[0]); end
    spr_cs_i = 1; spr_write_i = 1; spr_addr_i = 2'b01;
    #1;
    checks++; if (stall_cpu_o !== 1'b0) begin failures++; $display("FAIL flush_empty_stall got=%b exp=0", stall_cpu_o); end
    tick;
    spr_cs_i = 0; spr_write_i = 0;
    tick;
    checks++; if (st.st_req_o !== 1'b0 || stall_cpu_o !== 1'b0) begin failures++; $display("FAIL flush_empty_req got=%b%b exp=00", st.st_req_o, stall_cpu_o); end
  endtask
  task automatic test_simultaneous;
    spr_cs_i = 1; spr_write_i = 1; spr_addr_i = 2'b10; spr_dat_i = 32'h5000;
    op(16'h00AA, 5'd8);
    tick;
    bit_op_i = 0; spr_cs_i = 0; spr_write_i = 0;
    serve(1, 0);
    checks++; if (q_b.size() !== 1 || q_b[0] !== 8'hAA || q_a[0] !== 32'h5000) begin failures++; $display("FAIL simul_addr got=%h@%h exp=aa@5000", q_b[0], q_a[0]); end
    st.st_ack_i = 1;
    tick;
    st.st_ack_i = 0;
    spr_rd(2'b10, rd);
    checks++; if (rd !== 32'h5001) begin failures++; $display("FAIL stray_ack got=%h exp=5001", rd); end
    spr_cs_i = 1; spr_write_i = 1; spr_addr_i = 2'b01;
    op(16'h0001, 5'd1);
    tick;
    bit_op_i = 0; spr_cs_i = 0; spr_write_i = 0;
    tick;
    checks++; if (st.st_req_o !== 1'b0) begin failures++; $display("FAIL simul_flush_req got=%b exp=0", st.st_req_o); end
    spr_rd(2'b00, rd);
    checks++; if (rd !== 32'd1) begin failures++; $display("FAIL simul_flush_cnt got=%0d exp=1", rd); end
    spr_wr(2'b01, 32'h0);
    serve(2, 0);
    checks++; if (q_b.size() !== 2 || q_b[0] !== 8'hFF || q_a[0] !== 32'h5001 || q_a[1] !== 32'h5002) begin failures++; $display("FAIL simul_pad got=%h@%h exp=ff@5001", q_b[0], q_a[0]); end
    spr_rd(2'b11, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL reserved_rd got=%h exp=0", rd); end
  endtask
  task automatic test_reset_mid;
    op(16'h003C, 5'd8);
    tick;
    bit_op_i = 0;
    tick; tick;
    checks++; if (st.st_req_o !== 1'b1) begin failures++; $display("FAIL mid_pending got=%b exp=1", st.st_req_o); end
    rst_ni = 0;
    #1;
    checks++; if (st.st_req_o !== 1'b0 || stall_cpu_o !== 1'b0) begin failures++; $display("FAIL mid_abort got=%b%b exp=00", st.st_req_o, stall_cpu_o); end
    tick;
    rst_ni = 1;
    tick;
    spr_rd(2'b00, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", rd); end
    spr_rd(2'b10, rd);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL mid_addr got=%h exp=0", rd); end
  endtask
  initial begin
    st.st_ack_i = 0;
    test_reset;
    test_merge_small;
    test_emit;
    test_stuff;
    test_long;
    test_flush;
    test_simultaneous;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/or1200_vlx_ctrl.md
Name: or1200_vlx_ctrl

Overview:
- Sequencer for the OR1200 VLX (variable-length bit packing) path used by the JPEG Huffman encoder.
- Accepts bit-write operations from the CPU and left-justifies the bits into a 32-bit accumulator.
- Drains whole bytes to the data-store port over a req/ack handshake, inserts JPEG 0x00 stuffing after every 0xFF, and stalls the CPU while draining.
- Owns the VLX SPRs: base/current store address, bit count and flush.

Parameters:
- ADDR_W, 32, store address width.
- ACC_W, 32, accumulator width; must be ≥ 24.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- bit_op_i  in  1  one-cycle pulse: write bit_len_i LSBs of bit_val_i.
- bit_val_i  in  16  bits to write, right-aligned.
- bit_len_i  in  5  bit count, 0..16; 0 = no-op.
- spr_cs_i  in  1  VLX SPR select.
- spr_write_i  in  1  SPR write strobe.
- spr_addr_i  in  2  SPR index.
- spr_dat_i  in  32  SPR write data.
- spr_dat_o  out  32  SPR read data, combinational.
- stall_cpu_o  out  1  stall request to the CPU pipeline.
- st_req_o  out  1  byte store request.
- st_addr_o  out  ADDR_W  byte store address.
- st_byte_o  out  8  byte to store.
- st_ack_i  in  1  store accepted; single-cycle pulse.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE, acc=0, cnt=0, addr=0.
  - st_req_o=0, st_byte_o=0, st_addr_o=0, stall_cpu_o=0.
  - Reset mid-operation aborts immediately; st_req_o drops in the same cycle as reset assertion.
- SPR map:
  - 2'b00: read {26'b0, cnt}; writes ignored.
  - 2'b01: write = flush; reads 0.
  - 2'b10: write loads addr; read returns addr.
  - 2'b11: reserved; reads 0, writes ignored.
- Bit merge (IDLE only, bit_op_i=1):
  - v = bit_val_i & ((1<<len)-1).
  - acc |= v << (ACC_W - cnt - len); cnt += len.
  - Bits are MSB-first.
- Accumulator invariant: cnt ≤ 7 in IDLE, so cnt+len ≤ 23 and never overflows.
- FSM states: IDLE, EMIT, STUFF.
  - IDLE → EMIT at the clock edge after a merge when new cnt ≥ 8.
  - IDLE → EMIT on flush with cnt > 0:
    - bits below the valid count are filled with 1 (JPEG pad) up to the byte boundary;
    - cnt is rounded up to 8.
  - Flush with cnt = 0 is a no-op.
  - EMIT: st_req_o=1, st_byte_o=acc[ACC_W-1 -: 8], st_addr_o=addr. All three hold stable until st_ack_i.
  - EMIT on ack: addr += 1; acc <<= 8; cnt -= 8. Next state:
    - byte == 8'hFF → STUFF;
    - else remaining cnt ≥ 8 → EMIT;
    - else → IDLE.
  - STUFF: st_req_o=1, st_byte_o=8'h00, st_addr_o=addr.
  - STUFF on ack: addr += 1. Next state is EMIT if cnt ≥ 8, else IDLE.
  - st_req_o deasserts for at least the cycle after each ack. Back-to-back bytes therefore take ≥ 2 cycles each.
- Latency: bit_op_i in cycle 0 → st_req_o high in cycle 1; zero-wait ack → st_req_o low in cycle 2.
- stall_cpu_o (combinational) = (state ≠ IDLE) | (bit_op_i & cnt+bit_len_i ≥ 8) | (flush write & cnt > 0).
  - Low in the cycle state returns to IDLE.
- Events outside IDLE: bit_op_i and flush are ignored (CPU is stalled). An addr SPR write is also ignored.
- Simultaneous events in IDLE:
  - bit_op + addr write: both take effect; the first emitted byte uses the new addr.
  - bit_op + flush: bit_op wins; flush ignored.
- st_ack_i while st_req_o=0: ignored.
- addr wraps modulo 2^ADDR_W.

Decomposition:
- Package or1200_vlx_pkg:
  - vlx_state_t enum {IDLE, EMIT, STUFF};
  - SPR index constants VLX_SPR_CNT=2'b00, VLX_SPR_FLUSH=2'b01, VLX_SPR_ADDR=2'b10;
  - JPEG_MARKER=8'hFF, JPEG_STUFF=8'h00.
- Sub-module or1200_vlx_bitbuf: accumulator plus count, with merge, pad and shift-by-8 ports. The FSM, address counter, SPR decode and stall logic stay in or1200_vlx_ctrl.

Test Plan:
1. Reset; write addr=0x1000; bit_op val=0x5 len=3 → no st_req_o, stall_cpu_o=0, SPR cnt reads 3.
2. Then bit_op val=0x1F len=5 → stall_cpu_o=1 in the same cycle; st_byte_o=0xBF at 0x1000 held through a 3-cycle ack delay; addr reads 0x1001; cnt=0; stall_cpu_o low at IDLE.
3. addr=0x2000; bit_op val=0xFF len=8 → store 0xFF@0x2000, then 0x00@0x2001; addr=0x2002; st_req_o low for one cycle between the two stores.
4. cnt=7 (val=0x7F len=7) then bit_op val=0xFFFF len=16 → stores 0xFF@A, 0x00@A+1, 0xFF@A+2, 0x00@A+3; cnt=7; acc top bits = 7'b1111111.
5. cnt=3 with bits 101, flush → 0xBF stored. Second flush with cnt=0 → no st_req_o, stall_cpu_o stays 0.
6. Reset asserted while in EMIT with ack withheld → st_req_o=0 and stall_cpu_o=0 in the same cycle; after release, cnt=0 and addr=0.
